// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time stage.
// - state_t     : FSM state encoding for pwm_dead_time
// - DW_DEFAULT  : default width of dead_time and of the dead-time counter
// - is_dead()   : true for the two dead (both-outputs-low) states
package pwm_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DEAD_TO_LO = 3'd1,
    LO_ON      = 3'd2,
    DEAD_TO_HI = 3'd3,
    HI_ON      = 3'd4
  } state_t;

  function automatic logic is_dead(input state_t s);
    return (s == DEAD_TO_LO) || (s == DEAD_TO_HI);
  endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter that times the dead interval.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (count clears to 0)
//   load         : load load_val (has priority over dec)
//   dec          : decrement by one
//   load_val     : value loaded on load
//   zero         : count is zero
module pwm_dt_counter
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [DW-1:0] load_val,
  output logic          zero
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_dead_time.sv
// Complementary gate-drive generator with programmable dead time.
// Turns the single-ended pwm_in into out_hi/out_lo, inserting a dead
// interval (both low) of max(dead_time,1) cycles at every transition.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : 0 forces outputs low and clears a latched fault
//   fault         : fault request, latched until enable drops
//   pwm_in        : single-ended PWM, same clock domain
//   dead_time     : dead interval in cycles, sampled on dead-state entry
//   out_hi/out_lo : registered high-/low-side drive
//   dead_active   : registered, 1 while in a dead state
//   fault_latched : registered sticky fault flag
module pwm_dead_time
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          fault,
  input  logic          pwm_in,
  input  logic [DW-1:0] dead_time,
  output logic          out_hi,
  output logic          out_lo,
  output logic          dead_active,
  output logic          fault_latched
);

  state_t        state, next_state;
  logic          pwm_q;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [DW-1:0] load_val;

  // A dead_time of 0 still yields one dead cycle.
  assign load_val = (dead_time == '0) ? '0 : dead_time - DW'(1);

  pwm_dt_counter #(.DW(DW)) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pwm_q         <= 1'b0;
      out_hi        <= 1'b0;
      out_lo        <= 1'b0;
      dead_active   <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state       <= next_state;
      pwm_q       <= pwm_in;
      out_hi      <= (next_state == HI_ON);
      out_lo      <= (next_state == LO_ON);
      dead_active <= is_dead(next_state);
      if (!enable) begin
        fault_latched <= 1'b0;
      end else if (fault) begin
        fault_latched <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    cnt_dec    = 1'b0;
    if (!enable || fault) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fault_latched) begin
            next_state = pwm_q ? DEAD_TO_HI : DEAD_TO_LO;
          end
        end
        LO_ON: begin
          if (pwm_q) next_state = DEAD_TO_HI;
        end
        HI_ON: begin
          if (!pwm_q) next_state = DEAD_TO_LO;
        end
        // A reversal during the dead interval swallows the pulse and
        // restarts the full interval toward the other side.
        DEAD_TO_HI: begin
          if (!pwm_q)        next_state = DEAD_TO_LO;
          else if (cnt_zero) next_state = HI_ON;
          else               cnt_dec    = 1'b1;
        end
        DEAD_TO_LO: begin
          if (pwm_q)         next_state = DEAD_TO_HI;
          else if (cnt_zero) next_state = LO_ON;
          else               cnt_dec    = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
    // Any entry into a dead state (including dead-to-dead) reloads the timer.
    cnt_load = is_dead(next_state) && (next_state != state);
  end

endmodule

// File: tb/tb_pwm_dead_time.sv
module tb_pwm_dead_time;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       fault;
  logic       pwm_in;
  logic [7:0] dead_time;
  logic       out_hi, out_lo, dead_active, fault_latched;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_dead_time #(.DW(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .fault         (fault),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .out_hi        (out_hi),
    .out_lo        (out_lo),
    .dead_active   (dead_active),
    .fault_latched (fault_latched)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: "which side we want" plus "dead cycles still owed".
  // A side is conducting only when running and no dead cycles remain.
  bit m_run, m_side, m_flt, m_q;
  int m_left;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_side = 0; m_flt = 0; m_q = 0; m_left = 0;
  endtask

  task automatic model_edge();
    bit q;
    q = m_q;
    if (!enable) begin
      m_run = 0; m_flt = 0;
    end else if (fault) begin
      m_run = 0; m_flt = 1;
    end else if (!m_run) begin
      if (!m_flt) begin
        m_run = 1; m_side = q; m_left = max1(int'(dead_time));
      end
    end else if (q != m_side) begin
      m_side = q; m_left = max1(int'(dead_time));
    end else if (m_left > 0) begin
      m_left--;
    end
    m_q = pwm_in;
  endtask

  function automatic logic [3:0] model_out();
    logic on;
    on = m_run && (m_left == 0);
    return {on && m_side, on && !m_side, m_run && (m_left > 0), m_flt};
  endfunction

  // One clock: drive at negedge, model advances at posedge, check just after.
  task automatic cyc(input logic en, input logic f, input logic p, input logic [7:0] dt);
    enable = en; fault = f; pwm_in = p; dead_time = dt;
    @(posedge clk);
    model_edge();
    #1;
    chk("outs", {out_hi, out_lo, dead_active, fault_latched}, model_out());
    chk("overlap", 32'(out_hi & out_lo), 32'd0);
    @(negedge clk);
  endtask

  logic [7:0] dt_r;
  logic       p_r;
  int         hold;
  logic [7:0] gcnt;

  initial begin
    reset_n = 1'b0; enable = 1'b0; fault = 1'b0; pwm_in = 1'b0; dead_time = 8'd0;
    model_reset();
    #1;
    chk("reset_state", {out_hi, out_lo, dead_active, fault_latched}, 4'b0000);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Start-up with dead_time=4, pwm low, then a rising edge with dead_time=3
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'd4);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 8'd3);
    // Asynchronous reset while driving high side
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", {out_hi, out_lo, dead_active, fault_latched}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero dead time, toggling every 10 cycles
    for (int t = 0; t < 6; t++)
      for (int i = 0; i < 10; i++) cyc(1, 0, t[0], 8'd0);

    // Short pulse swallowed with dead_time=5
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 8'd5);
    cyc(1, 0, 1, 8'd5); cyc(1, 0, 1, 8'd5);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 8'd5);

    // Fault pulse in HI_ON, pwm keeps toggling, then enable blip to clear
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 8'd2);
    cyc(1, 1, 1, 8'd2);
    for (int i = 0; i < 10; i++) cyc(1, 0, i[1], 8'd2);
    cyc(0, 0, 1, 8'd2);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 8'd2);
    // Fault still high when enable returns: relatches
    cyc(0, 1, 1, 8'd2);
    cyc(1, 1, 1, 8'd2);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'd2);
    cyc(0, 0, 0, 8'd2);

    // PWM-generator-like drive: duty 0, 255 and 1, dead_time=2
    gcnt = 8'd0;
    for (int i = 0; i < 40; i++) begin cyc(1, 0, 1'b0, 8'd2); gcnt++; end
    for (int i = 0; i < 40; i++) begin cyc(1, 0, (gcnt < 8'd255), 8'd2); gcnt++; end
    gcnt = 8'd0;
    for (int i = 0; i < 300; i++) begin cyc(1, 0, (gcnt < 8'd1), 8'd2); gcnt++; end

    // Randomized run: random holds, dead times, mid-interval dead_time changes,
    // occasional fault pulses and enable drops
    p_r = 1'b0; dt_r = 8'd3; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        p_r  = ~p_r;
        hold = $urandom_range(1, 12);
        if ($urandom_range(0, 3) == 0) dt_r = 8'($urandom_range(0, 7));
      end
      hold--;
      cyc(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 2), p_r,
          ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : dt_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_dead_time.md
Name: pwm_dead_time

Overview:
Downstream stage of the PWM generator. It consumes the single-ended pwm_out waveform and produces a complementary high-side/low-side gate-drive pair. A programmable dead interval keeps both outputs low at every transition. The block also provides enable gating and a sticky fault shutdown, and sits between the PWM counter/comparator and the gate-driver pins.

Parameters:
DW, 8, width of dead_time and of the internal dead-time down-counter

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = drive outputs from pwm_in; 0 = force both outputs low and clear a latched fault
fault  input  1  active-high fault request; its effect is latched until enable is deasserted
pwm_in  input  1  single-ended PWM from the generator, same clock domain
dead_time  input  DW  dead interval in clk cycles, sampled on entry to a dead state
out_hi  output  1  high-side drive, registered
out_lo  output  1  low-side drive, registered
dead_active  output  1  1 while the FSM is in a dead state, registered
fault_latched  output  1  sticky fault flag, registered

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, out_hi=0, out_lo=0, dead_active=0, fault_latched=0, pwm_q=0, counter=0.
- pwm_in is registered once into pwm_q. The FSM acts only on pwm_q.
- States: IDLE, DEAD_TO_LO, LO_ON, DEAD_TO_HI, HI_ON.
- Outputs are dedicated registers loaded from the next-state decode:
  - out_hi=1 only in HI_ON.
  - out_lo=1 only in LO_ON.
  - dead_active=1 only in DEAD_TO_LO and DEAD_TO_HI.
  - out_hi and out_lo are never 1 in the same cycle.
- Dead-state entry loads counter <= (dead_time==0) ? 0 : dead_time-1.
  - Each cycle in a dead state: if counter==0, exit; else counter decrements.
  - Effective dead interval = max(dead_time,1) cycles.
- IDLE: with enable=1 and fault_latched=0, go to DEAD_TO_HI if pwm_q=1, else DEAD_TO_LO. Outputs are never driven directly from IDLE.
- LO_ON: pwm_q=1 -> DEAD_TO_HI. HI_ON: pwm_q=0 -> DEAD_TO_LO.
- DEAD_TO_HI:
  - counter==0 and pwm_q=1 -> HI_ON.
  - pwm_q=0 at any point -> DEAD_TO_LO with the counter reloaded. The pulse is swallowed; the full dead interval is re-timed.
- DEAD_TO_LO: mirror image of DEAD_TO_HI (counter==0 and pwm_q=0 -> LO_ON; pwm_q=1 -> DEAD_TO_HI with reload).
- Latency from a pwm_q rising edge in LO_ON:
  - out_lo falls 1 cycle later.
  - out_hi rises max(dead_time,1)+1 cycles after pwm_q.
  - The falling edge is symmetric.
- fault=1 and enable=1 in any state:
  - fault_latched<=1 and state<=IDLE on the next edge; both outputs are 0 from that edge.
  - fault_latched stays 1, regardless of the fault level, until enable=0.
- enable=0 in any state: state<=IDLE, outputs 0, fault_latched<=0 on the next edge.
  - If fault is still 1 when enable returns, fault relatches on that cycle.
- Priority when events coincide: reset > enable=0 > fault > pwm_q transitions.
- dead_time changes mid-interval have no effect until the next dead-state entry.
- Reset asserted mid-interval forces both outputs to 0 immediately (asynchronously).

Decomposition:
- Shared package pwm_pkg: state encoding localparams (IDLE, DEAD_TO_LO, LO_ON, DEAD_TO_HI, HI_ON) and the default DW.
- One sub-module, pwm_dt_counter: a loadable DW-bit down-counter with load, dec, load value, and zero flag.
- The FSM, input register and output registers stay in pwm_dead_time.

Test Plan:
1. Reset/enable: reset_n=0 mid-HI_ON -> out_hi=0 and out_lo=0 immediately. Then enable=1, pwm_in=0, dead_time=4 -> dead_active for 4 cycles, then out_lo=1.
2. Dead time at a rising edge: dead_time=3, steady LO_ON, pwm_in 0->1 and held -> out_lo falls 2 edges after the pwm_in change. out_hi rises 3 cycles after that. No cycle has out_hi=out_lo=1.
3. Zero dead time: dead_time=0, toggle pwm_in every 10 cycles -> exactly 1 dead cycle at each transition.
4. Short pulse swallowed: dead_time=5, LO_ON, pwm_in high for 2 cycles -> out_hi stays 0. A fresh 5-cycle dead interval is followed by out_lo=1.
5. Fault: 1-cycle fault pulse during HI_ON -> both outputs 0 next edge, fault_latched=1 while pwm_in keeps toggling. enable=0 for 1 cycle, then 1 -> fault_latched=0; restart goes through a dead interval.
6. Duty extremes: drive from the PWM generator with duty_cycle=0 and duty_cycle=255, dead_time=2 -> steady out_lo=1 or out_hi=1 respectively after the start-up dead interval. Duty_cycle=1 gives a 1-cycle pulse, which is swallowed.
